// File: rtl/pooling_bram_ctrl.sv
// Pooling feature BRAM sequencer.
// FILL streams pooled words into the BRAM at sequential addresses; DRAIN
// walks the BRAM in groups of GROUP words through its registered SE taps,
// handing each group to the SE block under a valid/ready handshake.
// Only addresses and enables come from here; SE data goes BRAM -> SE directly.
module pooling_bram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 100352,
    parameter int GROUP      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [19:0]           cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  bram_wr_rd_en,
    output logic [31:0]           bram_wr_addr,
    output logic [19:0]           bram_rd_addr,
    output logic [DATA_WIDTH-1:0] bram_data_in,
    output logic                  se_valid,
    input  logic                  se_ready,
    output logic                  se_last
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    localparam logic [19:0] DEPTH_W = 20'(DEPTH);
    localparam logic [19:0] GROUP_W = 20'(GROUP);

    state_t      state;
    logic [19:0] wr_ptr;
    logic [19:0] rd_ptr;
    logic [19:0] len;
    logic        primed;
    logic        err_q;

    logic        len_ok;
    logic        wr_fire;
    logic        se_hs;

    // Job length must be a whole number of SE groups (GROUP is fixed at 4,
    // so the low two bits carry the multiple-of-group test) and fit the BRAM.
    assign len_ok  = (cfg_len != '0) && (cfg_len[1:0] == 2'b00) && (cfg_len <= DEPTH_W);
    assign wr_fire = in_valid & in_ready;
    assign se_hs   = se_valid & se_ready;

    assign busy          = (state == FILL) || (state == DRAIN);
    assign done          = (state == DONE);
    assign err           = err_q;
    assign in_ready      = (state == FILL);
    assign bram_wr_rd_en = wr_fire;
    assign bram_wr_addr  = {12'b0, wr_ptr};
    assign bram_data_in  = in_data;
    assign se_valid      = primed;
    assign se_last       = primed & (rd_ptr == len - GROUP_W);

    // Read-address lookahead: the BRAM taps lag the address by one cycle, so
    // on an accepted group the next group's base is presented now. The final
    // group never looks ahead, keeping the address inside the job.
    assign bram_rd_addr = (se_hs && !se_last) ? rd_ptr + GROUP_W : rd_ptr;

    // Job sequencer: IDLE -> FILL -> DRAIN -> DONE -> IDLE, plus the err pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            len    <= '0;
            primed <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len    <= cfg_len;
                            wr_ptr <= '0;
                            state  <= FILL;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (wr_fire) begin
                        wr_ptr <= wr_ptr + 20'd1;
                        if (wr_ptr == len - 20'd1) begin
                            state  <= DRAIN;
                            rd_ptr <= '0;
                            primed <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle issues the read of group 0; taps are
                    // valid from the following cycle on.
                    primed <= 1'b1;
                    if (se_hs) begin
                        rd_ptr <= rd_ptr + GROUP_W;
                        if (se_last) begin
                            state  <= DONE;
                            primed <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pooling_bram_ctrl.sv
// Bench for pooling_bram_ctrl: a small BRAM model with four registered SE
// taps, a word scoreboard filled as words are written and drained four at a
// time as the SE side accepts groups.
module tb_pooling_bram_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [19:0]   cfg_len;
    logic          busy, done, err;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          bram_wr_rd_en;
    logic [31:0]   bram_wr_addr;
    logic [19:0]   bram_rd_addr;
    logic [DW-1:0] bram_data_in;
    logic          se_valid, se_ready, se_last;

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0]         sb [$];
    logic [DW-1:0]         mem [0:255];
    logic [3:0][DW-1:0]    taps;

    always #5 clk = ~clk;

    pooling_bram_ctrl #(.DATA_WIDTH(DW), .DEPTH(100352), .GROUP(4)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len),
        .busy(busy), .done(done), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bram_wr_rd_en(bram_wr_rd_en), .bram_wr_addr(bram_wr_addr),
        .bram_rd_addr(bram_rd_addr), .bram_data_in(bram_data_in),
        .se_valid(se_valid), .se_ready(se_ready), .se_last(se_last)
    );

    // BRAM model: synchronous write, four registered read taps.
    always @(posedge clk) begin
        if (bram_wr_rd_en) mem[bram_wr_addr[7:0]] <= bram_data_in;
        for (int i = 0; i < 4; i++) taps[i] <= mem[8'(bram_rd_addr + 20'(i))];
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        nvec++;
        if ({busy, done, err, in_ready, bram_wr_rd_en, se_valid, se_last} !== 7'b0 ||
            bram_wr_addr !== 32'd0 || bram_rd_addr !== 20'd0) begin
            nerr++;
            $display("FAIL reset_held: ctl=%b wr_addr=%0h rd_addr=%0h, want all 0",
                     {busy, done, err, in_ready, bram_wr_rd_en, se_valid, se_last}, bram_wr_addr, bram_rd_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        nvec++;
        if ({busy, done, err, in_ready, se_valid, se_last} !== 6'b0 || bram_rd_addr !== 20'd0) begin
            nerr++;
            $display("FAIL reset_release: ctl=%b rd_addr=%0h, want 0", {busy, done, err, in_ready, se_valid, se_last}, bram_rd_addr);
        end
    endtask

    task automatic do_start(input logic [19:0] len);
        @(negedge clk);
        start = 1'b1;
        cfg_len = len;
        @(negedge clk);
        start = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0) begin
            nerr++;
            $display("FAIL start_accept: busy=%b in_ready=%b err=%b, want 1 1 0", busy, in_ready, err);
        end
    endtask

    // Streams len words base, base+1, ... with in_valid following vpat
    // (bit 0 first; 1 after the pattern ends). Optionally pulses start with
    // cfg_len=16 at cycle glitch_at.
    task automatic do_fill(input int len, input logic [DW-1:0] base, input logic [15:0] vpat,
                           input int vlen, input int glitch_at);
        int cnt = 0;
        int cyc = 0;
        while (cnt < len && cyc < 64) begin
            in_valid = (cyc < vlen) ? vpat[cyc] : 1'b1;
            in_data  = base + DW'(cnt);
            if (cyc == glitch_at) begin
                start = 1'b1;
                cfg_len = 20'd16;
            end else begin
                start = 1'b0;
            end
            #1;
            nvec++;
            if (in_ready !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || bram_wr_rd_en !== in_valid) begin
                nerr++;
                $display("FAIL fill_ctl cyc %0d: in_ready=%b busy=%b err=%b wr_en=%b, want 1 1 0 %b",
                         cyc, in_ready, busy, err, bram_wr_rd_en, in_valid);
            end
            if (in_valid) begin
                nvec++;
                if (bram_wr_addr !== 32'(cnt) || bram_data_in !== in_data) begin
                    nerr++;
                    $display("FAIL fill_write: addr=%0h data=%0h, want addr=%0h data=%0h",
                             bram_wr_addr, bram_data_in, cnt, in_data);
                end
                sb.push_back(in_data);
                cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (cnt < len) begin
            nvec++;
            nerr++;
            $display("FAIL fill_timeout: %0d words written, want %0d", cnt, len);
        end
        #1;
        nvec++;
        if (in_ready !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            nerr++;
            $display("FAIL fill_to_drain: in_ready=%b busy=%b err=%b, want 0 1 0", in_ready, busy, err);
        end
    endtask

    // Drains the scoreboard; se_ready follows rpat on se_valid cycles (bit 0
    // first; 1 after the pattern ends).
    task automatic do_drain(input logic [7:0] rpat, input int rlen);
        logic [19:0]        ptr = 20'd0;
        logic [19:0]        exp_rd;
        logic [3:0][DW-1:0] prev_taps = '0;
        bit                 exp_valid, last_exp, hs, fin, prev_stall;
        int                 cyc = 0;
        int                 vi = 0;
        int                 groups = 0;
        int                 ngroups = sb.size() / 4;
        fin = 1'b0;
        prev_stall = 1'b0;
        while (!fin && cyc < 64) begin
            exp_valid = (cyc != 0);
            if (se_valid === 1'b1) begin
                se_ready = (vi < rlen) ? rpat[vi] : 1'b1;
                vi++;
            end else begin
                se_ready = 1'b1;
            end
            #1;
            last_exp = (sb.size() == 4);
            hs       = exp_valid && se_ready;
            exp_rd   = (hs && !last_exp) ? ptr + 20'd4 : ptr;
            nvec++;
            if (se_valid !== exp_valid || se_last !== (exp_valid && last_exp) || bram_rd_addr !== exp_rd ||
                busy !== 1'b1 || in_ready !== 1'b0 || bram_wr_rd_en !== 1'b0) begin
                nerr++;
                $display("FAIL drain_ctl cyc %0d: vld=%b last=%b rd=%0h busy=%b wen=%b, want %b %b %0h 1 0",
                         cyc, se_valid, se_last, bram_rd_addr, busy, bram_wr_rd_en,
                         exp_valid, exp_valid && last_exp, exp_rd);
            end
            if (exp_valid) begin
                nvec++;
                if (sb.size() < 4) begin
                    nerr++;
                    $display("FAIL drain_extra_group: %0d words left", sb.size());
                    fin = 1'b1;
                end else if (taps !== {sb[3], sb[2], sb[1], sb[0]}) begin
                    nerr++;
                    $display("FAIL drain_group %0d: taps=%h, want %h", groups, taps, {sb[3], sb[2], sb[1], sb[0]});
                end
                if (prev_stall) begin
                    nvec++;
                    if (taps !== prev_taps) begin
                        nerr++;
                        $display("FAIL stall_hold: taps=%h, want %h", taps, prev_taps);
                    end
                end
                prev_stall = !se_ready;
                prev_taps  = taps;
                if (se_ready && !fin) begin
                    repeat (4) void'(sb.pop_front());
                    ptr += 20'd4;
                    groups++;
                    if (last_exp) fin = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        se_ready = 1'b0;
        if (!fin) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: %0d groups accepted, want %0d", groups, ngroups);
        end
        #1;
        nvec++;
        if (done !== 1'b1 || busy !== 1'b0 || se_valid !== 1'b0 || groups != ngroups) begin
            nerr++;
            $display("FAIL done_pulse: done=%b busy=%b vld=%b groups=%0d, want 1 0 0 %0d",
                     done, busy, se_valid, groups, ngroups);
        end
        @(negedge clk);
        #1;
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL done_width: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_normal;
        do_start(20'd8);
        do_fill(8, 32'hA0, 16'h0, 0, -1);
        do_drain(8'hFF, 8);
    endtask

    task automatic test_backpressure;
        do_start(20'd12);
        do_fill(12, 32'h100, 16'h0, 0, -1);
        do_drain(8'b0001_1001, 5);
    endtask

    task automatic test_illegal;
        logic [19:0] bad [3];
        bad[0] = 20'd0;
        bad[1] = 20'd6;
        bad[2] = 20'd100356;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1;
            cfg_len = bad[k];
            in_valid = 1'b1;
            #1;
            nvec++;
            if (bram_wr_rd_en !== 1'b0 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL illegal_idle len %0d: wen=%b busy=%b, want 0 0", bad[k], bram_wr_rd_en, busy);
            end
            @(negedge clk);
            start = 1'b0;
            #1;
            nvec++;
            if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || bram_wr_rd_en !== 1'b0) begin
                nerr++;
                $display("FAIL illegal_err len %0d: err=%b busy=%b in_ready=%b wen=%b, want 1 0 0 0",
                         bad[k], err, busy, in_ready, bram_wr_rd_en);
            end
            @(negedge clk);
            #1;
            nvec++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL illegal_err_width len %0d: err=%b busy=%b, want 0 0", bad[k], err, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_gaps;
        do_start(20'd4);
        do_fill(4, 32'h200, 16'h0065, 7, -1);
        do_drain(8'hFF, 8);
    endtask

    task automatic test_start_in_fill;
        do_start(20'd8);
        do_fill(8, 32'h300, 16'h0, 0, 2);
        do_drain(8'hFF, 8);
    endtask

    task automatic test_reset_mid_job;
        do_start(20'd8);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + DW'(k);
            #1;
            nvec++;
            if (bram_wr_rd_en !== 1'b1 || bram_wr_addr !== 32'(k)) begin
                nerr++;
                $display("FAIL abort_write %0d: wen=%b addr=%0h, want 1 %0h", k, bram_wr_rd_en, bram_wr_addr, k);
            end
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = 32'hC3;
        #1;
        reset = 1'b1;
        #1;
        nvec++;
        if ({busy, done, err, in_ready, bram_wr_rd_en, se_valid, se_last} !== 7'b0 ||
            bram_wr_addr !== 32'd0 || bram_rd_addr !== 20'd0) begin
            nerr++;
            $display("FAIL abort_async: ctl=%b wr_addr=%0h rd_addr=%0h, want all 0",
                     {busy, done, err, in_ready, bram_wr_rd_en, se_valid, se_last}, bram_wr_addr, bram_rd_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL abort_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        do_start(20'd4);
        do_fill(4, 32'hD0, 16'h0, 0, -1);
        do_drain(8'hFF, 8);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        cfg_len  = '0;
        in_valid = 1'b0;
        in_data  = '0;
        se_ready = 1'b0;
        test_reset;
        test_normal;
        test_backpressure;
        test_illegal;
        test_gaps;
        test_start_in_fill;
        test_reset_mid_job;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
